serial_frame_receiver: RTL
==========================

# serial_frame_receiver

Serial-to-parallel receiver for the 24-bit framed audio link: one bit every CLKS_PER_BIT clocks, MSB first, plus a frame marker that is high for the whole last bit (bit 0) of every frame. It is the receive end of the DAC serial link. It loops the link back for self-test and accepts frames from external serial sources (ADC/codec) into the DrumsHeroe audio path. It locks to the marker's falling edge and presents each complete word with a one-cycle valid pulse.

## Interface
- WIDTH, 24, bits per frame; minimum 2.
- CLKS_PER_BIT, 2, clock cycles per serial bit; minimum 2.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high.
- data_in  in  1  serial data, MSB first, synchronous to clk.
- sync_in  in  1  frame marker, high during bit 0 of each frame.
- data_out  out  WIDTH  last complete word; held until the next word. Resets to 0.
- data_valid  out  1  one-cycle pulse in the cycle data_out takes a new word. Resets to 0.
- locked  out  1  high while in RECV. Resets to 0.
- frame_error  out  1  one-cycle pulse on a framing violation. Resets to 0, and is tied 0 unless FRAME_CHECK_EN is defined.

## Operation
- Registers:
  - sync_d: sync_in delayed one cycle; resets to 0.
  - shift_reg[WIDTH-1:0].
  - phase: 0..CLKS_PER_BIT-1.
  - bit_cnt: WIDTH-1..0.
  - state: HUNT or RECV.
- HUNT (reset state):
  - Wait for the sync falling edge, defined as sync_d==1 && sync_in==0.
  - The edge cycle counts as phase 0 of bit WIDTH-1.
  - Next cycle: state=RECV, phase=1, bit_cnt=WIDTH-1, shift_reg cleared.
  - data_in is ignored in HUNT.
- RECV:
  - phase counts up each cycle and wraps to 0 after CLKS_PER_BIT-1.
  - Sample point is phase==CLKS_PER_BIT-1: shift_reg <= {shift_reg[WIDTH-2:0], data_in}.
  - At a sample with bit_cnt!=0: bit_cnt decrements.
  - At a sample with bit_cnt==0:
    - data_out <= {shift_reg[WIDTH-2:0], data_in}.
    - data_valid <= 1 for one cycle.
    - bit_cnt <= WIDTH-1.
    - Stay in RECV. The next cycle is phase 0 of the next frame's MSB; back-to-back frames need no gap.
- Without FRAME_CHECK_EN, sync_in is ignored in RECV and the receiver free-runs after first lock.
- Reset mid-frame: the partial word is discarded, all state and outputs return to reset values, and the block returns to HUNT.
- sync_in high at reset release does not lock the receiver until it falls.

## Timing
- Take the sync falling-edge cycle as t.
- Bit k (counting from MSB index WIDTH-1) occupies cycles t+(WIDTH-1-k)*CLKS_PER_BIT through t+(WIDTH-k)*CLKS_PER_BIT-1.
- Each bit is sampled on the last cycle of its slot.
- data_out and data_valid update at t+WIDTH*CLKS_PER_BIT. With the default parameters this is t+48.
- Subsequent frames: data_valid repeats exactly every WIDTH*CLKS_PER_BIT cycles.
- locked rises at t+1 and falls the cycle after a frame_error, or on reset.

## Configuration
- FRAME_CHECK_EN defined:
  - At every sample point in RECV, sync_in must equal (bit_cnt==0).
  - On a mismatch: frame_error pulses for one cycle, data_valid stays low, data_out is kept, and state returns to HUNT.
  - The mismatching cycle is also tested for a falling edge on the following cycles, so relock can occur immediately.
- FRAME_CHECK_EN undefined:
  - No check is made, and frame_error is constant 0.

## Structure
- Shared package (audio link):
  - WIDTH default (24).
  - CLKS_PER_BIT default (2).
  - HUNT/RECV state encoding constants.
  - The transmitter uses the same package.
- One sub-module, rx_bit_timer, holds the phase and bit_cnt counters.
  - Outputs: sample strobe and last_bit flag.
  - Inputs: load (on lock) and clear (on error).
- The FSM, shift register and frame check stay in the top module.

## Test plan
- Drive a transmitter-equivalent model sending 24'hA5C3F0 after a sync falling edge at t. Expect data_out=24'hA5C3F0 and a single-cycle data_valid at t+48, with locked=1 from t+1.
- Continuous frames 24'h000001, 24'hFFFFFE, 24'h800000. Expect three valid pulses exactly 48 cycles apart, with matching data_out values.
- Assert reset at cycle t+20 of a frame. Expect all outputs 0 and state HUNT. The next full frame 24'h123456 after a fresh sync edge is received correctly.
- FRAME_CHECK_EN defined: raise sync_in during bit 12. Expect a frame_error pulse at the bit-12 sample, locked=0, no data_valid, and data_out unchanged. The next frame 24'h0F0F0F relocks and is received.
- FRAME_CHECK_EN undefined, same stimulus: expect frame_error=0, locked stays 1, and a data_valid pulse at t+48 with the shifted-in value.
- sync_in held high through reset release, then falling. Expect no lock before the falling edge, and correct capture of 24'h5A5A5A afterwards.

Source files
------------

// File: rtl/serial_frame_receiver_pkg.sv
// Audio link shared definitions: default frame geometry and receiver state encoding.
// Also imported by the matching serial transmitter.
package serial_frame_receiver_pkg;

    localparam int WIDTH_DEF        = 24;
    localparam int CLKS_PER_BIT_DEF = 2;

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } rx_state_t;

endpackage

// File: rtl/serial_frame_receiver_bit_timer.sv
// rx_bit_timer: bit phase and bit counter for the serial frame receiver.
// It produces the per-bit sample strobe and flags the last bit of a frame.
module rx_bit_timer
    import serial_frame_receiver_pkg::*;
#(
    parameter int WIDTH        = WIDTH_DEF,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic clear,
    input  logic run,
    output logic sample,
    output logic last_bit
);

    localparam int PH_W = $clog2(CLKS_PER_BIT);
    localparam int BC_W = $clog2(WIDTH);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLKS_PER_BIT - 1);
    localparam logic [BC_W-1:0] BC_TOP  = BC_W'(WIDTH - 1);

    logic [PH_W-1:0] phase;
    logic [BC_W-1:0] bit_cnt;
    logic            at_sample;

    assign at_sample = (phase == PH_LAST);

    // The lock cycle itself is phase 0 of the MSB, so loading starts at phase 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase   <= '0;
            bit_cnt <= BC_TOP;
        end else if (load) begin
            phase   <= PH_W'(1);
            bit_cnt <= BC_TOP;
        end else if (clear) begin
            phase   <= '0;
            bit_cnt <= BC_TOP;
        end else if (run) begin
            phase <= at_sample ? '0 : phase + PH_W'(1);
            if (at_sample) begin
                bit_cnt <= (bit_cnt == '0) ? BC_TOP : bit_cnt - BC_W'(1);
            end
        end
    end

    assign sample   = run && at_sample;
    assign last_bit = (bit_cnt == '0);

endmodule

// File: rtl/serial_frame_receiver.sv
// Serial-to-parallel receiver for the framed audio link, locking on the frame marker's falling edge.
// Optional framing check of the marker at every sample point is enabled by defining FRAME_CHECK_EN.
module serial_frame_receiver
    import serial_frame_receiver_pkg::*;
#(
    parameter int WIDTH        = WIDTH_DEF,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_in,
    input  logic             sync_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             locked,
    output logic             frame_error
);

    rx_state_t        state;
    rx_state_t        state_nxt;
    logic             sync_d;
    logic [WIDTH-1:0] shift_reg;
    logic             sample;
    logic             last_bit;
    logic             fall;
    logic             load;
    logic             check_err;
    logic             word_done;

    assign fall = sync_d && !sync_in;
    assign load = (state == HUNT) && fall;

`ifdef FRAME_CHECK_EN
    // The marker must be high exactly at the sample of bit 0 and low at every other sample.
    assign check_err = sample && (sync_in != last_bit);
`else
    assign check_err = 1'b0;
`endif

    assign word_done = sample && last_bit && !check_err;

    rx_bit_timer #(
        .WIDTH        (WIDTH),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .clear    (check_err),
        .run      (state == RECV),
        .sample   (sample),
        .last_bit (last_bit)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            HUNT: if (fall)      state_nxt = RECV;
            RECV: if (check_err) state_nxt = HUNT;
            default:             state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= HUNT;
            sync_d <= 1'b0;
        end else begin
            state  <= state_nxt;
            sync_d <= sync_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg  <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= word_done;
            if (load) begin
                shift_reg <= '0;
            end else if (sample) begin
                shift_reg <= {shift_reg[WIDTH-2:0], data_in};
            end
            if (word_done) begin
                data_out <= {shift_reg[WIDTH-2:0], data_in};
            end
        end
    end

`ifdef FRAME_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_error <= 1'b0;
        end else begin
            frame_error <= check_err;
        end
    end
`else
    assign frame_error = 1'b0;
`endif

    assign locked = (state == RECV);

endmodule
